// File: rtl/axis_pattern_source.sv
`timescale 1ns/1ps
// axis_pattern_source
// AXI-stream stimulus source. Emits NPKT packets (NPKT==0: run forever) of
// pkt_len beats each, with data from one of four patterns. Optional idle gaps
// follow each accepted beat. Generated data depends only on the configuration
// and on how many beats were accepted, never on when the sink was ready.
module axis_pattern_source #(
   parameter int DW    = 8,
   parameter int LEN_W = 16,
   parameter int NPKT  = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [LEN_W-1:0] pkt_len,
   input  logic [3:0]       throttle,
   input  logic [31:0]      seed,
   input  logic             tready,
   output logic             tvalid,
   output logic [DW-1:0]    tdata,
   output logic             tlast,
   output logic             busy,
   output logic             done,
   output logic [15:0]      pkt_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MODE_INCR   = 2'd0,
      MODE_RANDOM = 2'd1,
      MODE_ALPHA4 = 2'd2,
      MODE_CONST  = 2'd3
   } mode_e;

   localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
   localparam logic [31:0] NPKT_V      = 32'(NPKT);
   localparam bit          RUN_FOREVER = (NPKT == 0);

   // One step of the 32-bit right-shifting Galois LFSR.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

   state_e            state_q,   state_d;
   mode_e             mode_q,    mode_d;
   logic [LEN_W-1:0]  len_q,     len_d;
   logic [3:0]        thr_q,     thr_d;
   logic [DW-1:0]     const_q,   const_d;
   logic [31:0]       lfsr_q,    lfsr_d;
   logic [LEN_W-1:0]  idx_q,     idx_d;
   logic [15:0]       pkt_cnt_q, pkt_cnt_d;
   logic [3:0]        gap_q,     gap_d;

   logic              is_last;
   logic              final_beat;

   // Beat-position decode shared by the next-state and output logic.
   always_comb begin
      is_last    = (idx_q == (len_q - LEN_W'(1)));
      final_beat = is_last && !RUN_FOREVER &&
                   ((32'(pkt_cnt_q) + 32'd1) == NPKT_V);
   end

   // Next-state logic: run start, beat acceptance and gap countdown.
   always_comb begin
      // NOTE: every _d takes its _q value before any branch, so a path that
      // does not assign it holds state instead of inferring a latch.
      state_d   = state_q;
      mode_d    = mode_q;
      len_d     = len_q;
      thr_d     = thr_q;
      const_d   = const_q;
      lfsr_d    = lfsr_q;
      idx_d     = idx_q;
      pkt_cnt_d = pkt_cnt_q;
      gap_d     = gap_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               mode_d    = mode_e'(mode);
               len_d     = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
               thr_d     = throttle;
               const_d   = seed[DW-1:0];
               lfsr_d    = (seed == 32'h0) ? 32'h1 : seed;
               idx_d     = '0;
               pkt_cnt_d = '0;
               gap_d     = '0;
               state_d   = ST_SEND;
            end
         end

         ST_SEND: begin
            // Beat held until the sink takes it; nothing advances on a stall.
            if (tready) begin
               lfsr_d = lfsr_step(lfsr_q);
               if (is_last) begin
                  idx_d     = '0;
                  pkt_cnt_d = pkt_cnt_q + 16'd1;
               end else begin
                  idx_d     = idx_q + LEN_W'(1);
               end

               if (final_beat) begin
                  state_d = ST_DONE;
               end else if (thr_q != 4'd0) begin
                  state_d = ST_GAP;
                  gap_d   = thr_q;
               end
            end
         end

         ST_GAP: begin
            // Counts idle cycles regardless of tready.
            if (gap_q <= 4'd1) begin
               gap_d   = 4'd0;
               state_d = ST_SEND;
            end else begin
               gap_d   = gap_q - 4'd1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and configuration registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: the latched configuration is reset too, so every output is a
         // known zero straight out of reset rather than only the FSM state.
         state_q   <= ST_IDLE;
         mode_q    <= MODE_INCR;
         len_q     <= '0;
         thr_q     <= '0;
         const_q   <= '0;
         lfsr_q    <= '0;
         idx_q     <= '0;
         pkt_cnt_q <= '0;
         gap_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the
         // pre-edge values of the others regardless of statement order.
         state_q   <= state_d;
         mode_q    <= mode_d;
         len_q     <= len_d;
         thr_q     <= thr_d;
         const_q   <= const_d;
         lfsr_q    <= lfsr_d;
         idx_q     <= idx_d;
         pkt_cnt_q <= pkt_cnt_d;
         gap_q     <= gap_d;
      end
   end

   // Outputs decoded from registered state only; data is zero outside SEND.
   always_comb begin
      tvalid  = 1'b0;
      tdata   = '0;
      tlast   = 1'b0;
      busy    = (state_q == ST_SEND) || (state_q == ST_GAP);
      done    = (state_q == ST_DONE);
      pkt_cnt = pkt_cnt_q;

      if (state_q == ST_SEND) begin
         tvalid = 1'b1;
         tlast  = is_last;
         case (mode_q)
            MODE_INCR:   tdata = DW'(idx_q);
            MODE_RANDOM: tdata = lfsr_q[DW-1:0];
            MODE_ALPHA4: tdata = DW'({6'd0, lfsr_q[1:0]} + 8'h61);
            MODE_CONST:  tdata = const_q;
            default:     tdata = '0;
         endcase
      end
   end

endmodule

// File: doc/axis_pattern_source.md
# axis_pattern_source

Parametrised, synthesizable AXI-stream stimulus source for the compressor bench and for on-board self-test. It replaces the fixed random byte source. It adds configurable data width and packet count, selectable data patterns (incrementing, pseudo-random, low-entropy compressible, constant) and deterministic valid throttling. Generated data never depends on sink backpressure. It drives the compressor input port (`tvalid`/`tready`/`tdata`/`tlast`) and reports progress and completion to the bench or a control CPU.

## Interface
- `DW`, 8: data width; legal range 8..32.
- `LEN_W`, 16: width of the packet-length input.
- `NPKT`, 4: packets per run; 0 means run forever.
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `mode`  in  2  pattern: 0 INCR, 1 RANDOM, 2 ALPHA4, 3 CONST.
- `pkt_len`  in  LEN_W  beats per packet; 0 is treated as 1.
- `throttle`  in  4  idle cycles inserted after each accepted beat.
- `seed`  in  32  LFSR seed; also the CONST value.
- `tready`  in  1  sink ready.
- `tvalid`  out  1  beat valid.
- `tdata`  out  DW  beat data.
- `tlast`  out  1  last beat of packet.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until the next `start`.
- `pkt_cnt`  out  16  packets completed in the current run; wraps at 2^16.

## Operation
- The FSM has four states: IDLE, SEND, GAP and DONE.
- In IDLE or DONE, `start=1` does the following at the clock edge:
  - latches `mode`, `pkt_len` (0 becomes 1), `throttle` and `seed`;
  - loads the LFSR with `seed`, or with 1 if `seed==0`;
  - clears the beat index, `pkt_cnt` and `done`;
  - sets `busy=1` and enters SEND.
- While busy, `start` and all configuration inputs are ignored.
- Acceptance is `tvalid & tready`.
- In SEND, `tvalid=1` and `tdata`/`tlast` are held stable until accepted. On each accepted beat:
  - advance the LFSR one step;
  - increment the beat index, or reset it to 0 after `tlast`;
  - if `tlast`, increment `pkt_cnt`;
  - if that was the final beat of the final packet (`pkt_cnt+1==NPKT`, NPKT≠0), go to DONE;
  - else if `throttle>0`, go to GAP with counter = `throttle`;
  - else stay in SEND.
- GAP holds `tvalid=0` for exactly `throttle` cycles, then returns to SEND.
- DONE: `tvalid=0`, `busy=0`, `done=1`.
- LFSR: 32-bit Galois, right shift. Step: `lfsr = (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0)`.
- `tdata` by mode:
  - INCR: beat index mod 2^DW, restarting at 0 each packet;
  - RANDOM: `lfsr[DW-1:0]`;
  - ALPHA4: `8'h61 + lfsr[1:0]`, zero-extended to DW;
  - CONST: `seed[DW-1:0]`.
- `tlast=1` iff beat index == `pkt_len-1`.
- Reset values of all outputs: 0. The FSM is in IDLE.
- Reset asserted mid-run clears all outputs immediately (asynchronous). No beat is completed.

## Timing
- `start` sampled at edge N → `tvalid=1` with the first beat visible after edge N (cycle N+1).
- With `throttle=0` and `tready` held high, beats are back-to-back at one per cycle, including across packet boundaries.
- With `throttle=k`, the next beat is visible exactly k+1 cycles after the previous acceptance edge.
- `tready=0` stalls the source. It does not change the LFSR, the beat index or the throttle count. `tready` may toggle at any time.
- DONE is entered on the edge accepting the final beat. In that same cycle `tvalid=0` and `done=1`.
- `start` asserted in DONE begins a new run. `done` falls on the same edge that starts the run.

## Test plan
- DW=8, NPKT=2, mode INCR, `pkt_len`=3, `throttle`=0, `tready`=1 → beats 00,01,02(last),00,01,02(last) on six consecutive cycles; `pkt_cnt`=2; `done`=1 on the cycle after the final beat.
- RANDOM, `seed`=0x00000001, `pkt_len`=3 → `tdata` 0x01, 0x03, 0x02. Then rerun with `seed`=0 → identical sequence.
- RANDOM, `seed`=0x12345678, `tready` pseudo-randomly toggled vs. held at 1 → identical accepted-beat sequences; `tdata`/`tlast` never change while `tvalid=1` and `tready=0`.
- `throttle`=3, `pkt_len`=4 → exactly 3 cycles of `tvalid=0` between every pair of accepted beats, including across the packet boundary.
- `pkt_len`=0, NPKT=3, CONST, `seed`=0xA5 → three single-beat packets, each 0xA5 with `tlast=1`; `start` pulsed mid-run is ignored.
- `rstn` dropped mid-packet → all outputs 0 asynchronously. After release, a new `start` restarts at beat index 0 with `pkt_cnt`=0.
